j_chunk_streamer: RTL and testbench



---
 rtl/jmat_pkg.sv | 31 +++
 rtl/chunk_fifo.sv | 60 ++++++
 rtl/j_chunk_streamer.sv | 127 ++++++++++++
 tb/tb_j_chunk_streamer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jmat_pkg.sv
// jmat_pkg: J-matrix geometry helpers and streamer FSM states shared with MatMul.
// Rev 1.0
`default_nettype none

package jmat_pkg;

  localparam int MEM_BANDWIDTH_DEF   = 4096;
  localparam int VECTOR_SIZE_DEF     = 256;
  localparam int J_ELEMENT_WIDTH_DEF = 4;

  function automatic int cols_per_read(input int mem_bw, input int vec, input int ew);
    return mem_bw / (vec * ew);
  endfunction

  function automatic int num_chunks(input int mem_bw, input int vec, input int ew);
    return vec / cols_per_read(mem_bw, vec, ew);
  endfunction

  localparam int J_COLS_PER_READ = cols_per_read(MEM_BANDWIDTH_DEF, VECTOR_SIZE_DEF, J_ELEMENT_WIDTH_DEF);
  localparam int NUM_J_CHUNKS    = num_chunks(MEM_BANDWIDTH_DEF, VECTOR_SIZE_DEF, J_ELEMENT_WIDTH_DEF);
  localparam int ADDR_WIDTH      = $clog2(NUM_J_CHUNKS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } jstate_t;

endpackage

`default_nettype wire

// File: rtl/chunk_fifo.sv
// chunk_fifo: small valid/ready FIFO with occupancy count; storage is not reset.
// Rev 1.0
`default_nettype none

module chunk_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/j_chunk_streamer.sv
// j_chunk_streamer: sweeps J from memory chunk by chunk and streams unpacked chunks to MatMul.
// Rev 1.0
`default_nettype none

module j_chunk_streamer
  import jmat_pkg::*;
#(
  parameter  int MEM_BANDWIDTH   = 4096,
  parameter  int VECTOR_SIZE     = 256,
  parameter  int J_ELEMENT_WIDTH = 4,
  parameter  int FIFO_DEPTH      = 2,
  localparam int J_COLS_PER_READ = cols_per_read(MEM_BANDWIDTH, VECTOR_SIZE, J_ELEMENT_WIDTH),
  localparam int NUM_J_CHUNKS    = num_chunks(MEM_BANDWIDTH, VECTOR_SIZE, J_ELEMENT_WIDTH),
  localparam int ADDR_WIDTH      = $clog2(NUM_J_CHUNKS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [ADDR_WIDTH-1:0]      mem_req_addr,
  input  logic                       mem_rsp_valid,
  input  logic [MEM_BANDWIDTH-1:0]   mem_rsp_data,
  output logic                       chunk_valid,
  input  logic                       chunk_ready,
  output logic [J_ELEMENT_WIDTH-1:0] J_Matrix_chunk [VECTOR_SIZE][J_COLS_PER_READ],
  output logic [ADDR_WIDTH-1:0]      chunk_idx,
  output logic                       chunk_last
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int FIFO_W = MEM_BANDWIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_J_CHUNKS - 1);

  jstate_t               state;
  jstate_t               state_nxt;
  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        credit_used;
  logic                  credit_ok;
  logic [ADDR_WIDTH-1:0] rsp_idx;
  logic                  fifo_in_ready;
  logic                  req_fire;
  logic                  rsp_fire;
  logic                  chunk_fire;
  logic [FIFO_W-1:0]     fifo_out;
  logic [ADDR_WIDTH-1:0] head_idx;

  // Responses only arrive for issued requests; anything with nothing outstanding is stray.
  assign rsp_fire    = mem_rsp_valid && (outstanding != '0) && fifo_in_ready;
  assign req_fire    = mem_req_valid && mem_req_ready;
  assign chunk_fire  = chunk_valid && chunk_ready;
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
  assign credit_ok   = credit_used < (CNT_W + 1)'(FIFO_DEPTH);
  assign busy        = (state != ST_IDLE);

  chunk_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rsp_fire),
    .in_ready  (fifo_in_ready),
    .in_data   ({rsp_idx, mem_rsp_data}),
    .out_valid (chunk_valid),
    .out_ready (chunk_ready),
    .out_data  (fifo_out),
    .count     (fifo_count)
  );

  assign head_idx   = fifo_out[MEM_BANDWIDTH +: ADDR_WIDTH];
  assign chunk_idx  = chunk_valid ? head_idx : '0;
  assign chunk_last = chunk_valid && (head_idx == LAST_ADDR);

  for (genvar r = 0; r < VECTOR_SIZE; r++) begin : g_row
    for (genvar c = 0; c < J_COLS_PER_READ; c++) begin : g_col
      assign J_Matrix_chunk[r][c] = fifo_out[(r*J_COLS_PER_READ + c)*J_ELEMENT_WIDTH +: J_ELEMENT_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    mem_req_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req_valid = credit_ok;
        if (req_fire && (mem_req_addr == LAST_ADDR)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (chunk_fire && chunk_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_addr <= '0;
      rsp_idx      <= '0;
      outstanding  <= '0;
      done         <= 1'b0;
    end else begin
      done <= (state == ST_DRAIN) && chunk_fire && chunk_last;
      if (req_fire) mem_req_addr <= (mem_req_addr == LAST_ADDR) ? '0 : mem_req_addr + 1'b1;
      if (rsp_fire) rsp_idx <= (rsp_idx == LAST_ADDR) ? '0 : rsp_idx + 1'b1;
      case ({req_fire, rsp_fire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_j_chunk_streamer.sv
// tb_j_chunk_streamer: table-driven sweeps plus reset / restart corner sequences.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_j_chunk_streamer;

  localparam int MB = 4096, VS = 256, EW = 4, COLS = 4, NCH = 64, AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, mem_req_valid, chunk_valid, chunk_last;
  logic          mem_req_ready = 1'b0;
  logic          mem_rsp_valid = 1'b0;
  logic          chunk_ready = 1'b0;
  logic [AW-1:0] mem_req_addr, chunk_idx;
  logic [MB-1:0] mem_rsp_data = '0;
  logic [EW-1:0] jm [VS][COLS];

  always #5 clk = ~clk;

  j_chunk_streamer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .chunk_valid    (chunk_valid),
    .chunk_ready    (chunk_ready),
    .J_Matrix_chunk (jm),
    .chunk_idx      (chunk_idx),
    .chunk_last     (chunk_last)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] elem(input int pat, input int k, input int r, input int c);
    case (pat)
      0:       return 4'd1;
      1:       return 4'((r + c) % 16);
      default: return 4'((r * 3 + c + k) % 16);
    endcase
  endfunction

  function automatic logic [MB-1:0] make_word(input int pat, input int k);
    logic [MB-1:0] w;
    w = '0;
    for (int r = 0; r < VS; r++)
      for (int c = 0; c < COLS; c++)
        w[(r*COLS + c)*EW +: EW] = elem(pat, k, r, c);
    return w;
  endfunction

  // Shared configuration and statistics
  int lat_min = 1, lat_max = 1, rdy_mode = 0, pattern = 0, stall_left = 0;
  bit req_rdy_rand = 0, mem_en = 1;
  int req_cnt = 0, hs_cnt = 0, done_cnt = 0, exp_idx = 0;
  longint cyc = 0, last_fire_cyc = -10;

  typedef struct {int addr; longint due;} pend_t;
  pend_t pend[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder and chunk_ready driver
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) begin
        pend.push_back('{int'(mem_req_addr), cyc + longint'($urandom_range(lat_max, lat_min))});
        req_cnt++;
      end
      @(posedge clk);
      #1;
      if (!rst_n) pend.delete();
      if (mem_en) begin
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = make_word(pattern, pend[0].addr);
          void'(pend.pop_front());
        end else begin
          mem_rsp_valid = 1'b0;
          mem_rsp_data  = {128{32'hDEADBEEF}};
        end
        mem_req_ready = req_rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        case (rdy_mode)
          0: chunk_ready = 1'b1;
          1: chunk_ready = ($urandom_range(0, 99) < 60);
          default: begin
            if (hs_cnt >= 10 && stall_left > 0) begin
              if (stall_left == 1) begin
                check("stall_inflight", 64'(req_cnt - hs_cnt), 64'd2);
                check("stall_req_valid", 64'(mem_req_valid), 64'd0);
              end
              chunk_ready = 1'b0;
              stall_left--;
            end else begin
              chunk_ready = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Chunk monitor: order, content, hold stability and done timing
  logic [AW-1:0] hold_idx;
  logic [7:0]    hold_dat;
  bit            hold = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 0;
      end else begin
        if (hold) begin
          check("hold_valid", 64'(chunk_valid), 64'd1);
          check("hold_idx", 64'(chunk_idx), 64'(hold_idx));
          check("hold_data", 64'({jm[7][1], jm[255][3]}), 64'(hold_dat));
        end
        hold = chunk_valid && !chunk_ready;
        if (hold) begin
          hold_idx = chunk_idx;
          hold_dat = {jm[7][1], jm[255][3]};
        end
        if (chunk_valid && chunk_ready) begin
          int bad;
          bad = 0;
          check("chunk_idx", 64'(chunk_idx), 64'(exp_idx));
          check("chunk_last", 64'(chunk_last), 64'(exp_idx == NCH - 1));
          for (int r = 0; r < VS; r++)
            for (int c = 0; c < COLS; c++)
              if (jm[r][c] !== elem(pattern, exp_idx, r, c)) bad++;
          check("chunk_data", 64'(bad), 64'd0);
          if (chunk_last) last_fire_cyc = cyc;
          exp_idx++;
          hs_cnt++;
        end
        if (done) begin
          done_cnt++;
          check("done_timing", 64'(cyc), 64'(last_fire_cyc + 1));
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int lat_min, lat_max, rdy_mode;
    bit req_rand;
    int pattern;
    bit extra_start;
    int exp_chunks, exp_dones;
  } vec_t;

  vec_t vecs[5];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_stats;
    req_cnt = 0; hs_cnt = 0; done_cnt = 0; exp_idx = 0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 8000) begin
      step();
      n++;
    end
    check({name, "_finished"}, 64'(done_cnt > 0), 64'd1);
  endtask

  initial begin
    vecs[0] = '{1, 1, 0, 1'b0, 0, 1'b0, 64, 1};
    vecs[1] = '{1, 1, 2, 1'b0, 1, 1'b0, 64, 1};
    vecs[2] = '{1, 8, 1, 1'b0, 2, 1'b0, 64, 1};
    vecs[3] = '{3, 3, 1, 1'b1, 1, 1'b0, 64, 1};
    vecs[4] = '{1, 4, 0, 1'b1, 2, 1'b1, 64, 1};

    repeat (3) step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_chunk_valid", 64'(chunk_valid), 64'd0);
    check("rst_chunk_last", 64'(chunk_last), 64'd0);
    check("rst_chunk_idx", 64'(chunk_idx), 64'd0);
    check("rst_req_addr", 64'(mem_req_addr), 64'd0);
    rst_n = 1'b1;
    repeat (2) step();

    for (int v = 0; v < 5; v++) begin
      lat_min = vecs[v].lat_min; lat_max = vecs[v].lat_max;
      rdy_mode = vecs[v].rdy_mode; req_rdy_rand = vecs[v].req_rand;
      pattern = vecs[v].pattern; stall_left = 20;
      clear_stats();
      pulse_start();
      check("sweep_busy", 64'(busy), 64'd1);
      if (vecs[v].extra_start) begin
        repeat (30) step();
        pulse_start();
      end
      wait_done("sweep");
      repeat (10) step();
      check("sweep_chunks", 64'(hs_cnt), 64'(vecs[v].exp_chunks));
      check("sweep_dones", 64'(done_cnt), 64'(vecs[v].exp_dones));
      check("sweep_reqs", 64'(req_cnt), 64'(NCH));
      check("sweep_idle", 64'({busy, chunk_valid, mem_req_valid}), 64'd0);
    end

    // Start accepted in the done cycle
    lat_min = 1; lat_max = 2; rdy_mode = 0; req_rdy_rand = 0; pattern = 1;
    clear_stats();
    pulse_start();
    begin
      int n;
      n = 0;
      while (!done && n < 8000) begin
        step();
        n++;
      end
      check("done_seen", 64'(done), 64'd1);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_busy", 64'(busy), 64'd1);
    clear_stats();
    wait_done("restart");
    repeat (5) step();
    check("restart_chunks", 64'(hs_cnt), 64'(NCH));

    // Reset mid-sweep, then stray responses
    pattern = 2; rdy_mode = 0;
    clear_stats();
    pulse_start();
    begin
      int n;
      n = 0;
      while (hs_cnt < 30 && n < 4000) begin
        step();
        n++;
      end
      check("reached_chunk30", 64'(hs_cnt >= 30), 64'd1);
    end
    rst_n = 1'b0;
    #1;
    check("abort_outputs", 64'({busy, done, mem_req_valid, chunk_valid, chunk_last}), 64'd0);
    check("abort_idx", 64'({chunk_idx, mem_req_addr}), 64'd0);
    step();
    mem_en = 1'b0;
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = make_word(1, 5);
    for (int i = 0; i < 4; i++) begin
      step();
      check("stray_chunk_valid", 64'(chunk_valid), 64'd0);
    end
    mem_rsp_valid = 1'b0;
    step();
    check("stray_idle", 64'({busy, mem_req_valid, chunk_valid}), 64'd0);
    pend.delete();
    mem_en = 1'b1;
    clear_stats();
    pulse_start();
    wait_done("post_reset");
    repeat (5) step();
    check("post_reset_chunks", 64'(hs_cnt), 64'(NCH));
    check("post_reset_dones", 64'(done_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
